// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling and a 3-sample majority vote, feeding a show-ahead
// FIFO. Each FIFO entry holds the data word plus its parity and framing error flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_frame_err,
  output logic                        m_parity_err,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  output logic                        break_det,
  output logic                        busy
);
  localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV_W  = $clog2(OS_DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  logic rx_meta_q, rx_s_q;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0] tick_q, tick_d, bit_q, bit_d;
  logic s7_q, s7_d, s8_q, s8_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic zero_q, zero_d, brk_q, brk_d, ferr_q, ferr_d, perr_q, perr_d;
  logic brk_det_q, brk_det_d, overrun_q, overrun_d;
  logic tick, decide, bit_end, vote, last_stop, brk_now, frame_err_now, push;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ENT_W-1:0] wr_data, head;
  logic pop, full, wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Bit timing: 16 ticks per bit, vote from ticks 7/8/9, decision on tick 9.
  assign tick          = (div_q == DIV_W'(OS_DIV - 1));
  assign decide        = tick && (tick_q == 4'd9);
  assign bit_end       = tick && (tick_q == 4'd15);
  assign vote          = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign last_stop     = (bit_q == 4'(STOP_BITS - 1));
  assign brk_now       = (bit_q == 4'd0) ? (zero_q & ~vote) : brk_q;
  assign frame_err_now = ferr_q | ~vote;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = tick_q;
    s7_d    = s7_q;
    s8_d    = s8_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    brk_d   = brk_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    push      = 1'b0;
    brk_det_d = 1'b0;
    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd7) s7_d = rx_s_q;
        if (tick_q == 4'd8) s8_d = rx_s_q;
      end
    end
    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        tick_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
          bit_d   = '0;
          zero_d  = 1'b1;
          brk_d   = 1'b0;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (decide && vote) state_d = S_IDLE;
        else if (bit_end)   state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~vote;
          bit_d   = bit_q + 4'd1;
        end
        if (bit_end && bit_q == 4'(DATA_BITS)) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (decide) begin
          perr_d = ((^shift_q) ^ vote) != 1'(PARITY == 1);
          zero_d = zero_q & ~vote;
        end
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          ferr_d = frame_err_now;
          brk_d  = brk_now;
          bit_d  = bit_q + 4'd1;
          if (last_stop) begin
            bit_d = '0;
            if (brk_now) begin
              brk_det_d = 1'b1;
              state_d   = S_BRK;
            end else begin
              push    = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_BRK: begin
        if (decide && vote) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      tick_q    <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      bit_q     <= '0;
      shift_q   <= '0;
      zero_q    <= 1'b0;
      brk_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      brk_det_q <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      zero_q    <= zero_d;
      brk_q     <= brk_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      brk_det_q <= brk_det_d;
      overrun_q <= overrun_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign wr_data = {perr_q, frame_err_now, shift_q};
  assign pop     = (count_q != '0) && m_ready;
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    overrun_d = push && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head         = mem_q[rd_ptr_q];
  assign m_valid      = (count_q != '0);
  assign m_data       = m_valid ? head[DATA_BITS-1:0] : '0;
  assign m_frame_err  = m_valid & head[DATA_BITS];
  assign m_parity_err = m_valid & head[DATA_BITS+1];
  assign fifo_count   = count_q;
  assign overrun      = overrun_q;
  assign break_det    = brk_det_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 8N1, 8E1 and 7O2 instances driven by a directed vector table,
// hand-written corner sequences and random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 25_000;
  localparam int BIT      = CLK_FREQ / BAUD;

  typedef struct {
    int          cfg;
    logic [8:0]  data;
    bit          bad_par;
    logic [1:0]  stop;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic n_rx = 1'b1, e_rx = 1'b1, o_rx = 1'b1;
  logic n_ready = 1'b0, e_ready = 1'b0, o_ready = 1'b0;
  int   n_mode = 0, e_mode = 0, o_mode = 0;

  logic [7:0] n_data, e_data;
  logic [6:0] o_data;
  logic [4:0] n_cnt;
  logic [2:0] e_cnt, o_cnt;
  logic n_ferr, n_perr, n_valid, n_ovr, n_brk, n_busy;
  logic e_ferr, e_perr, e_valid, e_ovr, e_brk, e_busy;
  logic o_ferr, o_perr, o_valid, o_ovr, o_brk, o_busy;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_n1 (
    .clk(clk), .rst_n(rst_n), .rx(n_rx), .m_data(n_data), .m_frame_err(n_ferr),
    .m_parity_err(n_perr), .m_valid(n_valid), .m_ready(n_ready), .fifo_count(n_cnt),
    .overrun(n_ovr), .break_det(n_brk), .busy(n_busy));

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .clk(clk), .rst_n(rst_n), .rx(e_rx), .m_data(e_data), .m_frame_err(e_ferr),
    .m_parity_err(e_perr), .m_valid(e_valid), .m_ready(e_ready), .fifo_count(e_cnt),
    .overrun(e_ovr), .break_det(e_brk), .busy(e_busy));

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_o2 (
    .clk(clk), .rst_n(rst_n), .rx(o_rx), .m_data(o_data), .m_frame_err(o_ferr),
    .m_parity_err(o_perr), .m_valid(o_valid), .m_ready(o_ready), .fifo_count(o_cnt),
    .overrun(o_ovr), .break_det(o_brk), .busy(o_busy));

  // Consumers: 0 = stalled, 1 = always ready, 2 = random per cycle.
  always begin
    @(posedge clk);
    #1;
    n_ready = (n_mode == 2) ? (($urandom % 2) == 1) : (n_mode == 1);
    e_ready = (e_mode == 2) ? (($urandom % 2) == 1) : (e_mode == 1);
    o_ready = (o_mode == 2) ? (($urandom % 2) == 1) : (o_mode == 1);
  end

  logic [10:0] got_n[$], got_e[$], got_o[$];
  int n_brk_cnt = 0, n_ovr_cnt = 0, e_brk_cnt = 0, e_ovr_cnt = 0, o_brk_cnt = 0, o_ovr_cnt = 0;

  always @(negedge clk) begin
    if (n_valid && n_ready) got_n.push_back({n_perr, n_ferr, 1'b0, n_data});
    if (n_ovr) n_ovr_cnt++;
    if (n_brk) n_brk_cnt++;
  end
  always @(negedge clk) begin
    if (e_valid && e_ready) got_e.push_back({e_perr, e_ferr, 1'b0, e_data});
    if (e_ovr) e_ovr_cnt++;
    if (e_brk) e_brk_cnt++;
  end
  always @(negedge clk) begin
    if (o_valid && o_ready) got_o.push_back({o_perr, o_ferr, 2'b00, o_data});
    if (o_ovr) o_ovr_cnt++;
    if (o_brk) o_brk_cnt++;
  end

  int checks = 0, failures = 0;
  int rd_n = 0, rd_e = 0, rd_o = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nbits(input int cfg);
    return (cfg == 2) ? 7 : 8;
  endfunction
  function automatic int par_mode(input int cfg);
    return (cfg == 0) ? 0 : ((cfg == 1) ? 2 : 1);
  endfunction
  function automatic int nstop(input int cfg);
    return (cfg == 2) ? 2 : 1;
  endfunction

  // Parity bit that makes the total count of ones odd/even, optionally inverted.
  function automatic logic par_bit(input int cfg, input logic [8:0] d, input bit bad);
    int ones = 0;
    for (int i = 0; i < nbits(cfg); i++) ones += int'(d[i]);
    if (par_mode(cfg) == 1) return ((ones % 2) == 0) ^ bad;
    return ((ones % 2) == 1) ^ bad;
  endfunction

  // Frame-level reference: {is_break, parity_err, frame_err, data}.
  function automatic logic [11:0] model(input int cfg, input logic [8:0] d, input bit bad,
                                        input logic [1:0] stop);
    logic [8:0] dm;
    logic brk, ferr, perr;
    dm   = d & 9'((1 << nbits(cfg)) - 1);
    brk  = (dm == 9'd0) && (par_mode(cfg) == 0 || par_bit(cfg, d, bad) == 1'b0) && !stop[0];
    ferr = (nstop(cfg) == 1) ? !stop[0] : (stop != 2'b11);
    perr = (par_mode(cfg) != 0) && bad;
    return {brk, perr, ferr, dm};
  endfunction

  task automatic set_rx(input int cfg, input logic b);
    case (cfg)
      0:       n_rx = b;
      1:       e_rx = b;
      default: o_rx = b;
    endcase
  endtask

  task automatic drive(input int cfg, input logic b);
    set_rx(cfg, b);
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input int cfg, input logic [8:0] d, input bit bad,
                            input logic [1:0] stop);
    drive(cfg, 1'b0);
    for (int i = 0; i < nbits(cfg); i++) drive(cfg, d[i]);
    if (par_mode(cfg) != 0) drive(cfg, par_bit(cfg, d, bad));
    for (int i = 0; i < nstop(cfg); i++) drive(cfg, stop[i]);
    set_rx(cfg, 1'b1);
  endtask

  task automatic next_got(input int cfg, output logic [10:0] e, output bit ok);
    e  = '0;
    ok = 1'b0;
    case (cfg)
      0: if (rd_n < got_n.size()) begin e = got_n[rd_n]; rd_n++; ok = 1'b1; end
      1: if (rd_e < got_e.size()) begin e = got_e[rd_e]; rd_e++; ok = 1'b1; end
      default: if (rd_o < got_o.size()) begin e = got_o[rd_o]; rd_o++; ok = 1'b1; end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_n1"}, 32'({n_data, n_ferr, n_perr, n_valid, n_cnt, n_ovr, n_brk, n_busy}), 0);
    check({tag, "_e1"}, 32'({e_data, e_ferr, e_perr, e_valid, e_cnt, e_ovr, e_brk, e_busy}), 0);
    check({tag, "_o2"}, 32'({o_data, o_ferr, o_perr, o_valid, o_cnt, o_ovr, o_brk, o_busy}), 0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [10:0] e;
    logic [11:0] m;
    logic [10:0] exp_n[$], exp_o[$];
    logic [8:0] d;
    logic [1:0] stop;
    bit ok, bad;
    int g0, b0, v0, x_brk_n, x_brk_o;

    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, {2'b00, 9'h0A5}};
    vecs[1] = '{1, 9'h03C, 1'b1, 2'b11, {2'b10, 9'h03C}};
    vecs[2] = '{1, 9'h03C, 1'b0, 2'b11, {2'b00, 9'h03C}};
    vecs[3] = '{0, 9'h055, 1'b0, 2'b10, {2'b01, 9'h055}};
    vecs[4] = '{2, 9'h041, 1'b0, 2'b11, {2'b00, 9'h041}};
    vecs[5] = '{2, 9'h07F, 1'b0, 2'b11, {2'b00, 9'h07F}};

    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    n_mode = 1; e_mode = 1; o_mode = 1;
    repeat (BIT) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].cfg, vecs[i].data, vecs[i].bad_par, vecs[i].stop);
      repeat (2 * BIT) @(negedge clk);
      next_got(vecs[i].cfg, e, ok);
      check($sformatf("vec%0d_popped", i), 32'(ok), 1);
      check($sformatf("vec%0d_entry", i), 32'(e), 32'(vecs[i].exp));
      if (i == 0) check("vec0_busy_low", 32'(n_busy), 0);
    end

    // Break: line held low for two frame times on the 8N1 instance.
    b0 = n_brk_cnt;
    g0 = got_n.size();
    set_rx(0, 1'b0);
    repeat (20 * BIT - 2) @(negedge clk);
    check("brk_busy_held", 32'(n_busy), 1);
    set_rx(0, 1'b1);
    repeat (3 * BIT) @(negedge clk);
    check("brk_pulses", n_brk_cnt - b0, 1);
    check("brk_no_entry", got_n.size() - g0, 0);
    check("brk_fifo_count", 32'(n_cnt), 0);
    check("brk_busy_end", 32'(n_busy), 0);

    // Glitch: 5 ticks low then high.
    b0 = n_brk_cnt;
    v0 = n_ovr_cnt;
    g0 = got_n.size();
    set_rx(0, 1'b0);
    repeat (10) @(negedge clk);
    check("glitch_start_seen", 32'(n_busy), 1);
    repeat (10) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (2 * BIT) @(negedge clk);
    check("glitch_idle", 32'(n_busy), 0);
    check("glitch_no_entry", got_n.size() - g0 + n_brk_cnt - b0 + n_ovr_cnt - v0, 0);

    // Overrun: 17 back-to-back frames into a stalled 16-deep FIFO.
    n_mode = 0;
    repeat (4) @(negedge clk);
    v0 = n_ovr_cnt;
    g0 = got_n.size();
    for (int k = 0; k < 17; k++) send_frame(0, 9'(k), 1'b0, 2'b11);
    repeat (BIT) @(negedge clk);
    check("ovr_fifo_count", 32'(n_cnt), 16);
    check("ovr_pulses", n_ovr_cnt - v0, 1);
    check("ovr_no_pop", got_n.size() - g0, 0);
    n_mode = 1;
    repeat (40) @(negedge clk);
    check("drain_len", got_n.size() - g0, 16);
    for (int k = 0; k < 16; k++) begin
      next_got(0, e, ok);
      check($sformatf("drain_%0d", k), 32'(e), 32'({2'b00, 9'(k)}));
    end
    check("drain_empty", 32'(n_cnt), 0);

    // Random frames on 8N1 and 7O2 with random consumer stalls.
    n_mode = 2;
    o_mode = 2;
    b0 = n_brk_cnt;
    v0 = o_brk_cnt;
    x_brk_n = 0;
    x_brk_o = 0;
    for (int r = 0; r < 32; r++) begin
      int cfg;
      cfg  = (r % 2 == 0) ? 0 : 2;
      d    = 9'($urandom);
      if ($urandom % 8 == 0) d = '0;
      bad  = ($urandom % 4 == 0);
      stop = ($urandom % 3 == 0) ? 2'($urandom) : 2'b11;
      m    = model(cfg, d, bad, stop);
      if (cfg == 0) begin
        if (m[11]) x_brk_n++; else exp_n.push_back(m[10:0]);
      end else begin
        if (m[11]) x_brk_o++; else exp_o.push_back(m[10:0]);
      end
      send_frame(cfg, d, bad, stop);
      repeat (BIT) @(negedge clk);
    end
    repeat (BIT) @(negedge clk);
    n_mode = 1;
    o_mode = 1;
    repeat (20) @(negedge clk);
    foreach (exp_n[i]) begin
      next_got(0, e, ok);
      check($sformatf("rand_n1_%0d", i), 32'(e), 32'(exp_n[i]));
    end
    foreach (exp_o[i]) begin
      next_got(2, e, ok);
      check($sformatf("rand_o2_%0d", i), 32'(e), 32'(exp_o[i]));
    end
    check("rand_n1_extra", got_n.size() - rd_n, 0);
    check("rand_o2_extra", got_o.size() - rd_o, 0);
    check("rand_n1_breaks", n_brk_cnt - b0, x_brk_n);
    check("rand_o2_breaks", o_brk_cnt - v0, x_brk_o);

    // 7O2: one entry parked, then reset during the 4th data bit of a later frame.
    o_mode = 0;
    repeat (4) @(negedge clk);
    send_frame(2, 9'h041, 1'b0, 2'b11);
    repeat (BIT) @(negedge clk);
    check("o2_parked", 32'(o_cnt), 1);
    drive(2, 1'b0);
    for (int i = 0; i < 3; i++) drive(2, 1'b1);
    set_rx(2, 1'b1);
    repeat (BIT / 2) @(negedge clk);
    check("mid_frame_busy", 32'(o_busy), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("post_reset_empty", 32'({o_valid, o_cnt}), 0);
    check("post_reset_idle", 32'(o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
